// File: rtl/sisc_seq.sv
// sisc_seq: multi-cycle instruction sequencer for the SISC core.
//
// Owns the program counter and instruction register. Fetches over a req/valid
// handshake, decodes, and drives the ALU, register-file and status-register
// enables. Branches (absolute and relative) resolve against the status register.
// HALT and illegal opcodes park the sequencer in terminal states until reset.
//
// Ports:
//   clk          rising-edge clock
//   rst_f        synchronous active-low reset
//   imem_req     fetch request (high in FETCH)
//   imem_addr    fetch address, equal to pc
//   imem_valid   fetched instruction valid this cycle
//   imem_data    fetched instruction
//   stat         current status register contents
//   ir_q         latched instruction register
//   pc           program counter
//   alu_op       ALU operation, ir_q[27:24]; meaningful in EXECUTE
//   alu_imm_sel  ALU B operand is the immediate
//   stat_en      status register write enable
//   rf_we        register file write enable
//   wb_sel       writeback mux select (0 = ALU result)
//   halted       sequencer is in HALT
//   trap         sequencer is in TRAP (illegal opcode)

module sisc_seq #(
    parameter int unsigned    PC_W     = 16,
    parameter int unsigned    IR_W     = 32,
    parameter int unsigned    STAT_W   = 4,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_f,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_valid,
    input  logic [IR_W-1:0]   imem_data,
    input  logic [STAT_W-1:0] stat,
    output logic [IR_W-1:0]   ir_q,
    output logic [PC_W-1:0]   pc,
    output logic [3:0]        alu_op,
    output logic              alu_imm_sel,
    output logic              stat_en,
    output logic              rf_we,
    output logic              wb_sel,
    output logic              halted,
    output logic              trap
);

    typedef enum logic [2:0] {
        StFetch     = 3'd0,
        StDecode    = 3'd1,
        StExecute   = 3'd2,
        StWriteback = 3'd3,
        StHalt      = 3'd4,
        StTrap      = 3'd5
    } state_e;

    localparam logic [3:0] OpNop  = 4'd0;
    localparam logic [3:0] OpAluR = 4'd1;
    localparam logic [3:0] OpAluI = 4'd2;
    localparam logic [3:0] OpBra  = 4'd3;
    localparam logic [3:0] OpBrr  = 4'd4;
    localparam logic [3:0] OpHalt = 4'd15;

    state_e            r_state, w_state_nxt;
    logic [PC_W-1:0]   r_pc, w_pc_nxt;
    logic [IR_W-1:0]   r_ir, w_ir_nxt;

    logic [3:0]        w_opc;
    logic [3:0]        w_mm;
    logic [15:0]       w_imm;
    logic [STAT_W-1:0] w_mask;
    logic              w_taken;
    logic [PC_W-1:0]   w_imm_zx;
    logic [PC_W-1:0]   w_imm_sx;
    logic              w_unused_ir;

    assign w_opc  = r_ir[31:28];
    assign w_mm   = r_ir[27:24];
    assign w_imm  = r_ir[15:0];
    assign w_mask = w_mm[STAT_W-1:0];

    // An all-zero mask means unconditional; otherwise any selected flag set.
    assign w_taken = (w_mask == '0) || ((stat & w_mask) != '0);

    // Immediate fitted to PC width: zero-extended for BRA, sign-extended for BRR.
    generate
        if (PC_W > 16) begin : g_imm_wide
            assign w_imm_zx = {{(PC_W-16){1'b0}}, w_imm};
            assign w_imm_sx = {{(PC_W-16){w_imm[15]}}, w_imm};
        end else begin : g_imm_narrow
            assign w_imm_zx = w_imm[PC_W-1:0];
            assign w_imm_sx = w_imm[PC_W-1:0];
        end
    endgenerate

    generate
        if (IR_W > 32) begin : g_ir_wide
            assign w_unused_ir = ^{r_ir[IR_W-1:32], r_ir[23:16]};
        end else begin : g_ir_narrow
            assign w_unused_ir = ^r_ir[23:16];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_f) begin
            r_state <= StFetch;
            r_pc    <= RESET_PC;
            r_ir    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_ir    <= w_ir_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_ir_nxt    = r_ir;
        imem_req    = 1'b0;
        alu_imm_sel = 1'b0;
        stat_en     = 1'b0;
        rf_we       = 1'b0;
        halted      = 1'b0;
        trap        = 1'b0;

        unique case (r_state)
            StFetch: begin
                imem_req = 1'b1;
                if (imem_valid) begin
                    w_ir_nxt    = imem_data;
                    w_pc_nxt    = r_pc + PC_W'(1);
                    w_state_nxt = StDecode;
                end
            end
            StDecode: begin
                case (w_opc)
                    OpNop:                      w_state_nxt = StFetch;
                    OpHalt:                     w_state_nxt = StHalt;
                    OpAluR, OpAluI, OpBra, OpBrr: w_state_nxt = StExecute;
                    default:                    w_state_nxt = StTrap;
                endcase
            end
            StExecute: begin
                w_state_nxt = StFetch;
                case (w_opc)
                    OpAluR, OpAluI: begin
                        stat_en     = 1'b1;
                        alu_imm_sel = (w_opc == OpAluI);
                        w_state_nxt = StWriteback;
                    end
                    OpBra: begin
                        if (w_taken) w_pc_nxt = w_imm_zx;
                    end
                    OpBrr: begin
                        // r_pc already points past the branch instruction.
                        if (w_taken) w_pc_nxt = r_pc + w_imm_sx;
                    end
                    default: ;
                endcase
            end
            StWriteback: begin
                rf_we       = 1'b1;
                w_state_nxt = StFetch;
            end
            StHalt: halted = 1'b1;
            StTrap: trap   = 1'b1;
            default: w_state_nxt = StFetch;
        endcase
    end

    assign imem_addr = r_pc;
    assign pc        = r_pc;
    assign ir_q      = r_ir;
    assign alu_op    = w_mm;
    assign wb_sel    = 1'b0;

endmodule

// File: tb/tb_sisc_seq.sv
// Testbench for sisc_seq: a driver issues directed then random instructions
// and pushes per-instruction expectations from a reference model into a queue;
// a negedge monitor pops an entry at each fetch handshake and checks the
// outputs observed while that instruction executed.

module tb_sisc_seq;

    localparam int unsigned PC_W   = 16;
    localparam int unsigned IR_W   = 32;
    localparam int unsigned STAT_W = 4;
    localparam logic [15:0] RST_PC = 16'h0000;

    logic        clk = 1'b0;
    logic        rst_f = 1'b0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_valid = 1'b0;
    logic [31:0] imem_data = '0;
    logic [3:0]  stat = '0;
    logic [31:0] ir_q;
    logic [15:0] pc;
    logic [3:0]  alu_op;
    logic        alu_imm_sel, stat_en, rf_we, wb_sel, halted, trap;

    sisc_seq #(
        .PC_W    (PC_W),
        .IR_W    (IR_W),
        .STAT_W  (STAT_W),
        .RESET_PC(RST_PC)
    ) dut (
        .clk        (clk),
        .rst_f      (rst_f),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_valid (imem_valid),
        .imem_data  (imem_data),
        .stat       (stat),
        .ir_q       (ir_q),
        .pc         (pc),
        .alu_op     (alu_op),
        .alu_imm_sel(alu_imm_sel),
        .stat_en    (stat_en),
        .rf_we      (rf_we),
        .wb_sel     (wb_sel),
        .halted     (halted),
        .trap       (trap)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        logic [31:0] instr;
        int          nonfetch;
        int          n_stat;
        int          n_rf;
        logic [3:0]  alu_op;
        logic        imm_sel;
        logic        is_halt;
        logic        is_trap;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [15:0] model_pc = RST_PC;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: one instruction's observable effect, from the ISA rules.
    function automatic exp_t model(input logic [31:0] instr, input logic [3:0] st,
                                   input logic [15:0] pc_now, output logic [15:0] pc_next);
        exp_t e;
        int opc  = int'(instr[31:28]);
        int mask = int'(instr[27:24]);
        int imm  = int'(instr[15:0]);
        int pc1  = (int'(pc_now) + 1) % 65536;
        int s;
        bit taken = (mask == 0) || ((int'(st) & mask) != 0);
        e.addr = pc_now; e.instr = instr; e.nonfetch = 1; e.n_stat = 0; e.n_rf = 0;
        e.alu_op = instr[27:24]; e.imm_sel = 1'b0; e.is_halt = 1'b0; e.is_trap = 1'b0;
        pc_next = 16'(pc1);
        if (opc == 0) begin
            e.nonfetch = 1;
        end else if (opc == 1 || opc == 2) begin
            e.nonfetch = 3; e.n_stat = 1; e.n_rf = 1; e.imm_sel = (opc == 2);
        end else if (opc == 3) begin
            e.nonfetch = 2;
            if (taken) pc_next = 16'(imm);
        end else if (opc == 4) begin
            e.nonfetch = 2;
            s = (imm >= 32768) ? imm - 65536 : imm;
            if (taken) pc_next = 16'((pc1 + s + 65536) % 65536);
        end else if (opc == 15) begin
            e.is_halt = 1'b1;
        end else begin
            e.is_trap = 1'b1;
        end
        return e;
    endfunction

    // ---------------- monitor ----------------
    exp_t        cur;
    bit          have_cur = 0, term = 0, pend_rst = 0, both = 0;
    int          cnt_nf, cnt_stat, cnt_rf, term_bad = 0;
    logic [3:0]  seen_op;
    logic        seen_sel, seen_wb;
    logic [31:0] seen_ir;

    task automatic close_instr();
        check("nonfetch_cycles", cnt_nf, cur.nonfetch);
        check("stat_en_pulses", cnt_stat, cur.n_stat);
        check("rf_we_pulses", cnt_rf, cur.n_rf);
        check("rf_we_and_stat_en", both, 0);
        check("ir_q", seen_ir, cur.instr);
        check("halted", halted, cur.is_halt);
        check("trap", trap, cur.is_trap);
        if (cur.n_stat == 1) begin
            check("alu_op", seen_op, cur.alu_op);
            check("alu_imm_sel", seen_sel, cur.imm_sel);
            check("wb_sel", seen_wb, 0);
        end
        have_cur = 0;
    endtask

    always @(negedge clk) begin
        if (!rst_f) begin
            if (term) check("terminal_hold", term_bad, 0);
            q.delete();
            have_cur = 0; term = 0; term_bad = 0; pend_rst = 1;
        end else begin
            if (pend_rst) begin
                pend_rst = 0;
                check("rst_pc", pc, RST_PC);
                check("rst_ir", ir_q, 0);
                check("rst_flags", {imem_req, stat_en, rf_we, halted, trap}, 5'b10000);
            end
            if (term) begin
                if (imem_req || !(halted || trap)) term_bad++;
            end else if (halted || trap) begin
                check("stop_has_instr", have_cur, 1);
                if (have_cur) close_instr();
                term = 1;
            end else begin
                if (have_cur && !imem_req) begin
                    cnt_nf++;
                    if (cnt_nf == 1) seen_ir = ir_q;
                end
                if (stat_en) begin
                    cnt_stat++; seen_op = alu_op; seen_sel = alu_imm_sel;
                end
                if (rf_we) begin
                    cnt_rf++; seen_wb = wb_sel;
                end
                if (stat_en && rf_we) both = 1;
                if (imem_req && imem_valid) begin
                    if (have_cur) close_instr();
                    if (q.size() == 0) begin
                        check("fetch_with_empty_queue", q.size(), 1);
                    end else begin
                        cur = q.pop_front();
                        check("imem_addr", imem_addr, cur.addr);
                        check("pc_at_fetch", pc, cur.addr);
                        have_cur = 1; cnt_nf = 0; cnt_stat = 0; cnt_rf = 0; both = 0;
                    end
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        rst_f = 1'b0;
        imem_valid = 1'b0;
        repeat (cycles) step();
        rst_f = 1'b1;
        model_pc = RST_PC;
    endtask

    task automatic issue(input logic [31:0] instr, input logic [3:0] st, input int stalls);
        int   guard = 0;
        exp_t e;
        logic [15:0] nxt;
        // imem_valid toggles freely outside FETCH; the DUT must ignore it.
        while (!imem_req && guard < 30) begin
            imem_valid = 1'($urandom);
            imem_data  = $urandom;
            step();
            guard++;
        end
        if (!imem_req) begin
            check("fetch_req_timeout", imem_req, 1);
            return;
        end
        imem_valid = 1'b0;
        for (int s = 0; s < stalls; s++) begin
            imem_data = $urandom;
            step();
        end
        e = model(instr, st, model_pc, nxt);
        model_pc = nxt;
        q.push_back(e);
        imem_valid = 1'b1;
        imem_data  = instr;
        stat       = st;
        step();
        imem_valid = 1'b0;
        imem_data  = $urandom;
    endtask

    logic [31:0] d_ins[12] = '{32'h1300_0000, 32'h0000_0000, 32'h2A00_1234, 32'h3200_0040,
                               32'h3200_0040, 32'h3000_0123, 32'h4100_0010, 32'h4800_0010,
                               32'h3000_0001, 32'h4000_FFFC, 32'h0000_0000, 32'h0000_0000};
    logic [3:0]  d_st[12]  = '{4'h0, 4'h0, 4'h0, 4'h2, 4'h5, 4'h0, 4'h0, 4'h8,
                               4'h0, 4'h0, 4'h0, 4'h0};
    int          d_stl[12] = '{0, 3, 1, 0, 0, 0, 0, 0, 0, 2, 0, 0};

    initial begin
        logic [31:0] ins;
        int          r;
        do_reset(2);

        for (int i = 0; i < 12; i++) issue(d_ins[i], d_st[i], d_stl[i]);
        // pc has wrapped to 0: HALT there, hold, then reset.
        issue(32'hF000_0000, 4'h0, 0);
        repeat (20) step();
        do_reset(1);
        issue(32'h7000_0000, 4'h0, 1);
        repeat (10) step();
        do_reset(1);

        // Reset during EXECUTE of an ALU_I: no writeback may follow.
        issue(32'h2500_0007, 4'h0, 0);
        step();
        rst_f = 1'b0;
        imem_valid = 1'b0;
        step();
        rst_f = 1'b1;
        model_pc = RST_PC;

        for (int round = 0; round < 8; round++) begin
            for (int k = 0; k < 20; k++) begin
                ins = $urandom;
                r = $urandom_range(0, 9);
                if (r == 0)      ins[31:28] = 4'd0;
                else if (r < 4)  ins[31:28] = 4'($urandom_range(1, 2));
                else if (r < 7)  ins[31:28] = 4'd3;
                else             ins[31:28] = 4'd4;
                issue(ins, 4'($urandom), $urandom_range(0, 2));
            end
            ins = $urandom;
            ins[31:28] = (round % 2 == 0) ? 4'd15 : 4'($urandom_range(5, 14));
            issue(ins, 4'($urandom), 0);
            repeat (8) step();
            do_reset(1 + (round % 2));
        end
        repeat (3) step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        n_fail++;
        $display("FAIL global_timeout: simulation did not finish");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sisc_seq.md
Name: sisc_seq

Overview:
- Parametrised multi-cycle instruction sequencer for the SISC core. Generalises the fixed control block.
- Owns the PC and instruction register, fetches over a valid/req handshake, and decodes.
- Drives ALU, register-file and status-register enables.
- Resolves conditional branches against the status register. Adds relative branches, HALT and an illegal-opcode trap.

Parameters:
- PC_W, 16, PC and instruction-address width
- IR_W, 32, instruction width; must be >= 32
- STAT_W, 4, status register width; mask field uses the low STAT_W bits of ir[27:24]
- RESET_PC, 0, PC value loaded at reset

Ports:
- clk  in  1  clock, rising edge
- rst_f  in  1  synchronous active-low reset
- imem_req  out  1  fetch request
- imem_addr  out  PC_W  fetch address (= pc)
- imem_valid  in  1  instruction data valid this cycle
- imem_data  in  IR_W  fetched instruction
- stat  in  STAT_W  current status register contents
- ir_q  out  IR_W  latched instruction
- pc  out  PC_W  program counter
- alu_op  out  4  ALU operation = ir_q[27:24]; valid in EXECUTE
- alu_imm_sel  out  1  1 = ALU B operand is the immediate
- stat_en  out  1  status register write enable
- rf_we  out  1  register file write enable
- wb_sel  out  1  writeback mux select; 0 = ALU result
- halted  out  1  HALT state
- trap  out  1  TRAP state (illegal opcode)

Behaviour:
- Instruction fields:
  - opc = ir_q[31:28]
  - mm = ir_q[27:24]
  - imm = ir_q[15:0]
- Opcodes:
  - 0 NOP
  - 1 ALU_R
  - 2 ALU_I
  - 3 BRA: absolute branch
  - 4 BRR: relative branch
  - 15 HALT
  - All others illegal
- States: FETCH, DECODE, EXECUTE, WRITEBACK, HALT, TRAP.
- Reset (rst_f==0 at a rising edge, in any state, including mid-fetch):
  - state=FETCH, pc=RESET_PC, ir_q=0.
  - All enables, halted and trap = 0 the following cycle.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - Holds until imem_valid==1 at an edge; then ir_q<=imem_data, pc<=pc+1 (mod 2^PC_W), go to DECODE.
  - imem_valid is ignored outside FETCH.
- DECODE (1 cycle):
  - NOP -> FETCH.
  - HALT -> HALT.
  - Illegal -> TRAP.
  - Otherwise -> EXECUTE.
  - No enables asserted.
- EXECUTE (1 cycle):
  - ALU_R/ALU_I:
    - alu_op=mm, stat_en=1, alu_imm_sel=(opc==2) -> WRITEBACK.
  - BRA:
    - taken = (mm[STAT_W-1:0]==0) or ((stat & mm[STAT_W-1:0]) != 0).
    - If taken, pc<=imm zero-extended/truncated to PC_W.
    - -> FETCH.
  - BRR: same condition. If taken, pc<=pc+sign_extend(imm) mod 2^PC_W, using the already-incremented pc. -> FETCH.
  - Branches never assert stat_en or rf_we.
- WRITEBACK (1 cycle): rf_we=1, wb_sel=0 -> FETCH.
- HALT and TRAP:
  - Terminal; halted or trap held at 1, imem_req=0.
  - Left only by reset.
- Output timing:
  - Enables are combinational decodes of state and ir_q, high exactly one cycle each.
  - At most one of rf_we and stat_en is high in any cycle.
- Latency with imem_valid returned the same cycle as imem_req:
  - ALU instruction: 4 cycles.
  - Branch: 3 cycles.
  - NOP: 2 cycles.
  - Each cycle of imem_valid low adds one FETCH cycle.
- pc wraps from 2^PC_W-1 to 0 without a flag.

Test Plan:
- Reset then ALU_R: rst_f low 2 cycles, then imem_data=0x1300_0000 with imem_valid=1 -> imem_addr=0. Then DECODE, EXECUTE (alu_op=3, stat_en=1, alu_imm_sel=0), WRITEBACK (rf_we=1). FETCH with pc=1 on cycle 5.
- Fetch stall: hold imem_valid=0 for 3 cycles -> imem_req stays 1, imem_addr constant, pc unchanged. Instruction latched on the first valid cycle.
- BRA taken and not taken:
  - ir=0x3200_0040 with stat=0b0010 -> pc=0x0040.
  - Same ir with stat=0b0101 -> pc=old+1.
  - mm=0 -> always taken.
- BRR backwards wrap: pc=0x0001, ir=0x4000_FFFC -> pc after fetch=0x0002, after EXECUTE=0xFFFE.
- HALT/TRAP:
  - ir=0xF000_0000 -> halted=1 and imem_req=0 for 20 cycles.
  - ir=0x7000_0000 -> trap=1.
  - Reset then clears both and restarts at RESET_PC.
- Reset mid-operation: assert rst_f=0 during EXECUTE of an ALU_I -> no rf_we pulse occurs. Next cycle state=FETCH, pc=RESET_PC.
